rv_out_port: RTL and testbench

//  Parametrised memory-mapped output port for the RV_CPU core; generalises the fixed 10-bit `out` bus.
//  CPU store path writes through a valid/ready handshake with per-bit mask and four modes:

---
 rtl/rv_out_pkg.sv | 16 +
 rtl/rv_pulse_timer.sv | 36 +++
 rtl/rv_out_port.sv | 132 +++++++++++++
 tb/tb_rv_out_port.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/rv_out_pkg.sv
// rv_out_pkg
//   Shared definitions for the RV_CPU memory-mapped output port.
//   Holds the store-mode encodings and the FSM state type.
package rv_out_pkg;

  localparam logic [1:0] MODE_WRITE = 2'b00;
  localparam logic [1:0] MODE_SET   = 2'b01;
  localparam logic [1:0] MODE_CLR   = 2'b10;
  localparam logic [1:0] MODE_PULSE = 2'b11;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_PULSE = 1'b1
  } state_t;

endpackage

// File: rtl/rv_pulse_timer.sv
// rv_pulse_timer
//   Load/count-down timer that measures how long a PULSE value is held.
//   Loading takes priority; otherwise the count drops by one per cycle
//   and parks at zero.
// Ports
//   clk       in   rising-edge clock
//   reset     in   asynchronous, active-high
//   load      in   load load_val on the next edge
//   load_val  in   TW-bit reload value
//   done      out  count is zero
module rv_pulse_timer #(
  parameter  int PULSE_LEN = 4,
  localparam int TW        = $clog2(PULSE_LEN + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [TW-1:0] load_val,
  output logic          done
);

  logic [TW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - TW'(1);
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/rv_out_port.sv
// rv_out_port
//   Memory-mapped output port between the CPU store decode and the
//   top-level out pins. Stores arrive over a valid/ready handshake with a
//   per-bit mask and one of four modes (WRITE, SET, CLEAR, timed PULSE).
//   A registered change strobe and a saturating change counter are kept
//   for debug observation.
// Ports
//   clk       in   rising-edge clock
//   reset     in   asynchronous, active-high
//   wr_valid  in   write request
//   wr_ready  out  port can accept (IDLE only)
//   wr_mode   in   00 WRITE, 01 SET, 10 CLEAR, 11 PULSE
//   wr_data   in   write data
//   wr_mask   in   bit enable
//   out       out  registered output bus
//   out_chg   out  out changed on the last edge
//   chg_cnt   out  saturating count of out changes
//   busy      out  PULSE in progress
//
// state    | meaning
// ST_IDLE  | accepting stores, wr_ready high
// ST_PULSE | pulsed value on out, waiting for timer to expire
module rv_out_port
  import rv_out_pkg::*;
#(
  parameter int               WIDTH     = 10,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int               PULSE_LEN = 4,
  parameter int               CNT_W     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [1:0]       wr_mode,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [WIDTH-1:0] wr_mask,
  output logic [WIDTH-1:0] out,
  output logic             out_chg,
  output logic [CNT_W-1:0] chg_cnt,
  output logic             busy
);

  localparam int            TW         = $clog2(PULSE_LEN + 1);
  localparam logic [TW-1:0] PULSE_LOAD = TW'(PULSE_LEN - 1);

  state_t           state;
  logic [WIDTH-1:0] saved;
  logic [WIDTH-1:0] dm;
  logic [WIDTH-1:0] out_nxt;
  logic             accept;
  logic             pulse_start;
  logic             pulse_end;
  logic             tmr_done;
  logic             changed;

  // wr_ready is only high in IDLE, so accept implies IDLE.
  assign accept      = wr_valid & wr_ready;
  assign dm          = wr_data & wr_mask;
  assign pulse_start = accept && (wr_mode == MODE_PULSE);
  assign pulse_end   = (state == ST_PULSE) && tmr_done;

  always_comb begin
    out_nxt = out;
    if (pulse_end) begin
      out_nxt = saved;
    end else if (accept) begin
      case (wr_mode)
        MODE_WRITE: out_nxt = (out & ~wr_mask) | (wr_data & wr_mask);
        MODE_SET:   out_nxt = out | dm;
        MODE_CLR:   out_nxt = out & ~dm;
        MODE_PULSE: out_nxt = out ^ dm;
        default:    out_nxt = out;
      endcase
    end
  end

  assign changed = (out_nxt != out);

  // Loaded with PULSE_LEN-1: the accept edge plus PULSE_LEN-1 countdown
  // edges gives exactly PULSE_LEN cycles of the pulsed value.
  rv_pulse_timer #(
    .PULSE_LEN (PULSE_LEN)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (pulse_start),
    .load_val (PULSE_LOAD),
    .done     (tmr_done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      out      <= RESET_VAL;
      saved    <= '0;
      wr_ready <= 1'b1;
      busy     <= 1'b0;
      out_chg  <= 1'b0;
      chg_cnt  <= '0;
    end else begin
      out     <= out_nxt;
      out_chg <= changed;
      if (changed && (chg_cnt != '1)) begin
        chg_cnt <= chg_cnt + CNT_W'(1);
      end
      case (state)
        ST_IDLE: begin
          if (pulse_start) begin
            saved    <= out;
            state    <= ST_PULSE;
            wr_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        ST_PULSE: begin
          if (tmr_done) begin
            state    <= ST_IDLE;
            wr_ready <= 1'b1;
            busy     <= 1'b0;
          end
        end
        default: begin
          state    <= ST_IDLE;
          wr_ready <= 1'b1;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rv_out_port.sv
// tb_rv_out_port
//   Directed bench for rv_out_port (WIDTH=10, PULSE_LEN=4, CNT_W=8,
//   RESET_VAL=0). A behavioural model pushes the expected outputs for each
//   cycle into a queue when inputs are driven; they are popped and compared
//   after the clock edge. Key values are also checked against literals.
module tb_rv_out_port;
  import rv_out_pkg::*;

  localparam int W  = 10;
  localparam int PL = 4;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [1:0]    wr_mode = 2'b00;
  logic [W-1:0]  wr_data = '0;
  logic [W-1:0]  wr_mask = '0;
  logic [W-1:0]  out;
  logic          out_chg;
  logic [CW-1:0] chg_cnt;
  logic          busy;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [W-1:0]  out;
    logic          chg;
    logic [CW-1:0] cnt;
    logic          ready;
    logic          busy;
  } exp_t;

  exp_t exp_q[$];

  logic [W-1:0]  m_out;
  logic [W-1:0]  m_saved;
  logic [CW-1:0] m_cnt;
  logic          m_busy;
  int            m_tmr;

  rv_out_port #(
    .WIDTH     (W),
    .RESET_VAL ('0),
    .PULSE_LEN (PL),
    .CNT_W     (CW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_mode  (wr_mode),
    .wr_data  (wr_data),
    .wr_mask  (wr_mask),
    .out      (out),
    .out_chg  (out_chg),
    .chg_cnt  (chg_cnt),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_out   = '0;
    m_saved = '0;
    m_cnt   = '0;
    m_busy  = 1'b0;
    m_tmr   = 0;
    exp_q.delete();
  endtask

  task automatic drive(input logic v, input logic [1:0] m,
                       input logic [W-1:0] d, input logic [W-1:0] k);
    wr_valid = v;
    wr_mode  = m;
    wr_data  = d;
    wr_mask  = k;
  endtask

  // One clock: predict from the model, push, clock, pop, compare.
  task automatic step();
    exp_t         e;
    exp_t         g;
    logic [W-1:0] nxt;
    logic [W-1:0] dmv;
    dmv = wr_data & wr_mask;
    nxt = m_out;
    if (m_busy) begin
      if (m_tmr == 0) begin
        nxt    = m_saved;
        m_busy = 1'b0;
      end else begin
        m_tmr--;
      end
    end else if (wr_valid) begin
      case (wr_mode)
        2'b00: nxt = (m_out & ~wr_mask) | (wr_data & wr_mask);
        2'b01: nxt = m_out | dmv;
        2'b10: nxt = m_out & ~dmv;
        default: begin
          m_saved = m_out;
          nxt     = m_out ^ dmv;
          m_tmr   = PL - 1;
          m_busy  = 1'b1;
        end
      endcase
    end
    e.chg = (nxt !== m_out);
    if (e.chg && (m_cnt != 8'hFF)) m_cnt++;
    m_out   = nxt;
    e.out   = m_out;
    e.cnt   = m_cnt;
    e.ready = !m_busy;
    e.busy  = m_busy;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    g = exp_q.pop_front();
    chk("sb_out",   32'(out),      32'(g.out));
    chk("sb_chg",   32'(out_chg),  32'(g.chg));
    chk("sb_cnt",   32'(chg_cnt),  32'(g.cnt));
    chk("sb_ready", 32'(wr_ready), 32'(g.ready));
    chk("sb_busy",  32'(busy),     32'(g.busy));
  endtask

  initial begin
    // 1. asynchronous reset, checked before any edge
    #3 reset = 1'b1;
    #1;
    chk("rst_out",   32'(out),      32'h0);
    chk("rst_ready", 32'(wr_ready), 32'h1);
    chk("rst_cnt",   32'(chg_cnt),  32'h0);
    chk("rst_busy",  32'(busy),     32'h0);
    chk("rst_chg",   32'(out_chg),  32'h0);
    model_reset();
    @(posedge clk);
    #1 reset = 1'b0;
    drive(1'b0, MODE_WRITE, '0, '0);
    step();

    // 2. masked WRITE, then identical WRITE
    drive(1'b1, MODE_WRITE, 10'h3FF, 10'h0F0);
    step();
    chk("wr_out", 32'(out),     32'h0F0);
    chk("wr_chg", 32'(out_chg), 32'h1);
    chk("wr_cnt", 32'(chg_cnt), 32'h1);
    step();
    chk("wr_same_chg", 32'(out_chg), 32'h0);
    chk("wr_same_cnt", 32'(chg_cnt), 32'h1);

    // 3. SET then CLEAR
    drive(1'b1, MODE_SET, 10'h00F, 10'h3FF);
    step();
    chk("set_out", 32'(out), 32'h0FF);
    drive(1'b1, MODE_CLR, 10'h0F0, 10'h3FF);
    step();
    chk("clr_out", 32'(out),     32'h00F);
    chk("clr_cnt", 32'(chg_cnt), 32'h3);

    // 4. PULSE with a WRITE held on wr_valid throughout
    drive(1'b1, MODE_PULSE, 10'h300, 10'h3FF);
    step();
    chk("p_out",   32'(out),      32'h30F);
    chk("p_ready", 32'(wr_ready), 32'h0);
    chk("p_busy",  32'(busy),     32'h1);
    drive(1'b1, MODE_WRITE, 10'h000, 10'h3FF);
    for (int i = 1; i < PL; i++) begin
      step();
      chk("p_hold_out",   32'(out),      32'h30F);
      chk("p_hold_ready", 32'(wr_ready), 32'h0);
    end
    step();
    chk("p_rest_out",   32'(out),      32'h00F);
    chk("p_rest_ready", 32'(wr_ready), 32'h1);
    chk("p_rest_cnt",   32'(chg_cnt),  32'h5);
    step();
    chk("held_wr_out", 32'(out),     32'h000);
    chk("held_wr_cnt", 32'(chg_cnt), 32'h6);
    drive(1'b0, MODE_WRITE, '0, '0);
    step();

    // 5. reset in the second pulse cycle
    drive(1'b1, MODE_WRITE, 10'h0AA, 10'h3FF);
    step();
    drive(1'b1, MODE_PULSE, 10'h3FF, 10'h3FF);
    step();
    chk("p2_out", 32'(out), 32'h355);
    drive(1'b0, MODE_WRITE, '0, '0);
    step();
    #3 reset = 1'b1;
    #1;
    chk("midp_rst_out",   32'(out),      32'h0);
    chk("midp_rst_busy",  32'(busy),     32'h0);
    chk("midp_rst_ready", 32'(wr_ready), 32'h1);
    chk("midp_rst_cnt",   32'(chg_cnt),  32'h0);
    model_reset();
    @(posedge clk);
    #1 reset = 1'b0;
    drive(1'b1, MODE_WRITE, 10'h155, 10'h3FF);
    step();
    chk("post_rst_wr_out", 32'(out),     32'h155);
    chk("post_rst_wr_cnt", 32'(chg_cnt), 32'h1);

    // 6. counter saturation: every WRITE toggles bit 0
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, MODE_WRITE, (i % 2 == 1) ? 10'h3FF : 10'h000, 10'h001);
      step();
    end
    chk("sat_cnt", 32'(chg_cnt), 32'hFF);
    chk("sat_chg", 32'(out_chg), 32'h1);
    drive(1'b0, MODE_WRITE, '0, '0);
    step();
    chk("sat_hold_cnt", 32'(chg_cnt), 32'hFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
